// File: rtl/nbit_seq_comparator_pkg.sv
// Shared types and helpers for the nibble-serial comparator.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cmp_pkg;

    localparam int NIB_W = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COMPARE = 2'd1,
        DONE    = 2'd2
    } state_t;

    // Returns {lt, gt} for one nibble pair. Flipping the sign bit of both
    // operands turns a two's complement compare into an unsigned one.
    function automatic logic [1:0] nib_cmp(input logic [NIB_W-1:0] a,
                                           input logic [NIB_W-1:0] b,
                                           input logic             flip_msb);
        logic [NIB_W-1:0] ax;
        logic [NIB_W-1:0] bx;
        ax = a ^ {flip_msb, {(NIB_W-1){1'b0}}};
        bx = b ^ {flip_msb, {(NIB_W-1){1'b0}}};
        nib_cmp = {(ax < bx), (ax > bx)};
    endfunction

endpackage

// File: rtl/nbit_seq_comparator_if.sv
// Switch/button inputs and LED result outputs of the comparator.
// Latency: n/a (wiring only).
// Backpressure: none; buttons are edge events, results are held levels.
interface nbit_seq_comparator_if;

    logic [3:0] Y;
    logic       PB1;
    logic       PB2;
    logic       PB3;
    logic       PB4;
    logic       signed_mode;
    logic       less;
    logic       more;
    logic       equal;
    logic       busy;
    logic       done;

    modport master (
        output Y, PB1, PB2, PB3, PB4, signed_mode,
        input  less, more, equal, busy, done
    );

    modport slave (
        input  Y, PB1, PB2, PB3, PB4, signed_mode,
        output less, more, equal, busy, done
    );

endinterface

// File: rtl/nbit_seq_comparator_pb_edge_detect.sv
// Rising-edge detector for a debounced push-button level.
// Latency: pulse is combinational in the cycle the level first reads high.
// Backpressure: none; a held button yields exactly one pulse.
module pb_edge_detect (
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic pulse
);

    logic level_q;

    // Remember last cycle's level so only the low-to-high transition fires.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            level_q <= 1'b0;
        end else begin
            level_q <= level;
        end
    end

    assign pulse = level & ~level_q;

endmodule

// File: rtl/nbit_seq_comparator.sv
// Nibble-loaded operands, MSB-first nibble-serial compare with early exit.
// Latency: result and done k cycles after start (k = first differing nibble, or NIBBLES).
// Backpressure: button events arriving while busy are dropped, not queued.
module nbit_seq_comparator
    import cmp_pkg::*;
#(
    parameter int WIDTH = 8     // multiple of 4, at least 4
) (
    input logic                  clk,
    input logic                  rst_n,
    nbit_seq_comparator_if.slave bus
);

    localparam int NIBBLES = WIDTH / NIB_W;
    localparam int IDX_W   = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
    localparam logic [IDX_W-1:0] IDX_TOP = IDX_W'(NIBBLES - 1);

    logic ld_a_ev;
    logic ld_b_ev;
    logic start_ev;
    logic clr_ev;

    pb_edge_detect u_pb1 (.clk(clk), .rst_n(rst_n), .level(bus.PB1), .pulse(ld_a_ev));
    pb_edge_detect u_pb2 (.clk(clk), .rst_n(rst_n), .level(bus.PB2), .pulse(ld_b_ev));
    pb_edge_detect u_pb3 (.clk(clk), .rst_n(rst_n), .level(bus.PB3), .pulse(start_ev));
    pb_edge_detect u_pb4 (.clk(clk), .rst_n(rst_n), .level(bus.PB4), .pulse(clr_ev));

    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    state_t           state_q;
    logic [IDX_W-1:0] idx_q;
    logic             mode_r;
    logic             less_r;
    logic             more_r;
    logic             equal_r;
    logic             done_r;

    logic [NIB_W-1:0] a_nib;
    logic [NIB_W-1:0] b_nib;
    logic [1:0]       lt_gt;
    logic [WIDTH-1:0] a_shift;
    logic [WIDTH-1:0] b_shift;

    assign a_nib   = a_r[idx_q*NIB_W +: NIB_W];
    assign b_nib   = b_r[idx_q*NIB_W +: NIB_W];
    // Sign handling only matters on the top nibble; lower nibbles are magnitude.
    assign lt_gt   = nib_cmp(a_nib, b_nib, mode_r && (idx_q == IDX_TOP));
    // New nibble enters at the bottom; the oldest nibble drops off the top.
    assign a_shift = WIDTH'({a_r, bus.Y});
    assign b_shift = WIDTH'({b_r, bus.Y});

    // Operands, FSM, nibble index and result registers; clear > start > load.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            a_r     <= '0;
            b_r     <= '0;
            state_q <= IDLE;
            idx_q   <= '0;
            mode_r  <= 1'b0;
            less_r  <= 1'b0;
            more_r  <= 1'b0;
            equal_r <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_q)
                COMPARE: begin
                    if (lt_gt != 2'b00) begin
                        less_r  <= lt_gt[1];
                        more_r  <= lt_gt[0];
                        equal_r <= 1'b0;
                        done_r  <= 1'b1;
                        state_q <= DONE;
                    end else if (idx_q == '0) begin
                        less_r  <= 1'b0;
                        more_r  <= 1'b0;
                        equal_r <= 1'b1;
                        done_r  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        idx_q <= idx_q - IDX_W'(1);
                    end
                end
                // IDLE and DONE behave identically; DONE only marks held results.
                default: begin
                    if (clr_ev) begin
                        a_r     <= '0;
                        b_r     <= '0;
                        less_r  <= 1'b0;
                        more_r  <= 1'b0;
                        equal_r <= 1'b0;
                        state_q <= IDLE;
                    end else if (start_ev) begin
                        mode_r  <= bus.signed_mode;
                        idx_q   <= IDX_TOP;
                        state_q <= COMPARE;
                    end else begin
                        if (ld_a_ev) begin
                            a_r <= a_shift;
                        end
                        if (ld_b_ev) begin
                            b_r <= b_shift;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.less  = less_r;
    assign bus.more  = more_r;
    assign bus.equal = equal_r;
    assign bus.busy  = (state_q == COMPARE);
    assign bus.done  = done_r;

endmodule

// File: tb/tb_nbit_seq_comparator.sv
// Directed bench driving an 8-bit and a 16-bit comparator from shared buttons.
// Latency: checks done/result timing relative to the start edge.
// Backpressure: checks that events during a compare are ignored.
module tb_nbit_seq_comparator;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] y;
    logic       pb1;
    logic       pb2;
    logic       pb3;
    logic       pb4;
    logic       sm;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    nbit_seq_comparator_if if8 ();
    nbit_seq_comparator_if if16 ();

    assign if8.Y            = y;
    assign if8.PB1          = pb1;
    assign if8.PB2          = pb2;
    assign if8.PB3          = pb3;
    assign if8.PB4          = pb4;
    assign if8.signed_mode  = sm;
    assign if16.Y           = y;
    assign if16.PB1         = pb1;
    assign if16.PB2         = pb2;
    assign if16.PB3         = pb3;
    assign if16.PB4         = pb4;
    assign if16.signed_mode = sm;

    nbit_seq_comparator #(.WIDTH(8))  dut8  (.clk(clk), .rst_n(rst_n), .bus(if8));
    nbit_seq_comparator #(.WIDTH(16)) dut16 (.clk(clk), .rst_n(rst_n), .bus(if16));

    logic [4:0] o8;
    logic [4:0] o16;
    assign o8  = {if8.less,  if8.more,  if8.equal,  if8.busy,  if8.done};
    assign o16 = {if16.less, if16.more, if16.equal, if16.busy, if16.done};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mask bit0..3 = PB1..PB4; one press spans two edges so the button is seen low again
    task automatic press(input logic [3:0] mask, input logic [3:0] nib);
        y = nib;
        {pb4, pb3, pb2, pb1} = mask;
        step();
        {pb4, pb3, pb2, pb1} = 4'b0000;
        step();
    endtask

    task automatic start_cmp(input logic mode);
        sm  = mode;
        pb3 = 1'b1;
        step();
        pb3 = 1'b0;
    endtask

    task automatic expect_result(input string tag, input bit wide, input int lat,
                                 input logic [2:0] lme);
        int   cyc;
        logic d;
        cyc = 0;
        do begin
            step();
            cyc++;
            d = wide ? if16.done : if8.done;
        end while (!d && cyc < 40);
        chk({tag, "_lat"}, cyc, lat);
        chk({tag, "_res"}, wide ? o16[4:1] : o8[4:1], {lme, 1'b0});
        step();
        chk({tag, "_done_drop"}, wide ? if16.done : if8.done, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic seen;
        rst_n = 1'b0;
        y     = 4'h0;
        pb1   = 1'b0;
        pb2   = 1'b0;
        pb3   = 1'b0;
        pb4   = 1'b0;
        sm    = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        chk("rst_out8", o8, 5'b0);
        chk("rst_out16", o16, 5'b0);

        // A=0x05, B=0x00 unsigned: top nibbles equal, low nibble decides
        press(4'b0001, 4'h0);
        press(4'b0001, 4'h5);
        press(4'b0010, 4'h0);
        press(4'b0010, 4'h0);
        chk("t1_a", dut8.a_r, 8'h05);
        start_cmp(1'b0);
        chk("t1_busy", if8.busy, 1'b1);
        expect_result("t1", 1'b0, 2, 3'b010);

        // A=0xFF vs B=0xFE, then B=0xFF
        press(4'b0001, 4'hF);
        press(4'b0001, 4'hF);
        press(4'b0010, 4'hF);
        press(4'b0010, 4'hE);
        start_cmp(1'b0);
        expect_result("t2_gt", 1'b0, 2, 3'b010);
        press(4'b0010, 4'hF);
        press(4'b0010, 4'hF);
        start_cmp(1'b0);
        expect_result("t2_eq", 1'b0, 2, 3'b001);

        // A=0x80 vs B=0x01: unsigned more, signed less, both on the top nibble
        press(4'b0001, 4'h8);
        press(4'b0001, 4'h0);
        press(4'b0010, 4'h0);
        press(4'b0010, 4'h1);
        start_cmp(1'b0);
        expect_result("t3_uns", 1'b0, 1, 3'b010);
        start_cmp(1'b1);
        expect_result("t3_sgn", 1'b0, 1, 3'b100);
        chk("t3_a_kept", dut8.a_r, 8'h80);

        // 16-bit: clear, then 0x1234 vs 0x1235
        press(4'b1000, 4'h0);
        chk("clr16_out", o16, 5'b0);
        chk("clr16_a", dut16.a_r, 16'h0);
        press(4'b0001, 4'h1);
        press(4'b0001, 4'h2);
        press(4'b0001, 4'h3);
        press(4'b0001, 4'h4);
        press(4'b0010, 4'h1);
        press(4'b0010, 4'h2);
        press(4'b0010, 4'h3);
        press(4'b0010, 4'h5);
        start_cmp(1'b0);
        expect_result("t4", 1'b1, 4, 3'b100);

        // Holding PB1 for ten cycles shifts exactly once
        y   = 4'h6;
        pb1 = 1'b1;
        repeat (10) step();
        pb1 = 1'b0;
        step();
        chk("t4_hold", dut16.a_r, 16'h2346);

        // Load/clear pressed during a compare are ignored
        press(4'b0001, 4'h1);
        press(4'b0001, 4'h2);
        press(4'b0001, 4'h3);
        press(4'b0001, 4'h4);
        start_cmp(1'b0);
        y   = 4'h9;
        pb1 = 1'b1;
        pb4 = 1'b1;
        step();
        pb1 = 1'b0;
        pb4 = 1'b0;
        chk("t5_busy", if16.busy, 1'b1);
        chk("t5_a", dut16.a_r, 16'h1234);
        expect_result("t5", 1'b1, 3, 3'b100);

        // Start and load on the same edge in DONE: start wins
        sm  = 1'b0;
        y   = 4'h7;
        pb1 = 1'b1;
        pb3 = 1'b1;
        step();
        pb1 = 1'b0;
        pb3 = 1'b0;
        chk("t6_a", dut16.a_r, 16'h1234);
        expect_result("t6", 1'b1, 4, 3'b100);

        // Clear from DONE
        press(4'b1000, 4'h0);
        chk("t7_out", o16, 5'b0);
        chk("t7_b", dut16.b_r, 16'h0);

        // Simultaneous load, then reset in the middle of a compare
        press(4'b0011, 4'h1);
        press(4'b0011, 4'h2);
        press(4'b0011, 4'h3);
        press(4'b0011, 4'h4);
        chk("t8_ab_load", {dut16.a_r, dut16.b_r}, 32'h12341234);
        start_cmp(1'b0);
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk("t8_out", o16, 5'b0);
        chk("t8_ab", {dut16.a_r, dut16.b_r}, 32'h0);
        seen = 1'b0;
        repeat (6) begin
            step();
            if (if16.done) seen = 1'b1;
        end
        chk("t8_no_done", seen, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
